// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the block RAM port-A arbiter.
package bram_arb_pkg;

    // Width of one RAM word: 8 data bits plus 1 parity bit.
    localparam int DATA_W     = 9;
    localparam int DEF_ADDR_W = 11;

    typedef enum logic [1:0] {
        START,
        CLEAR,
        RUN
    } state_t;

endpackage

// File: rtl/bram_s9_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// The priority bit flips to the other requester after every grant, so
// contention produces strictly alternating grants.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0 = requester 0 holds priority, 1 = requester 1 holds priority.
    logic prio;

    assign gnt[0] = req[0] & (~req[1] | ~prio);
    assign gnt[1] = req[1] & (~req[0] |  prio);

    // Hand priority to whichever requester did not win this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/bram_s9_port_arbiter.sv
// Port-A sequencer for a 2K x 9 block RAM: clears the array after reset
// or on command, then shares the port between two requesters with a
// combinational grant and a fixed one-cycle read return.
module bram_s9_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = 9'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              ready,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_ssr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_di,
    output logic              ram_dip,
    input  logic [7:0]        ram_do,
    input  logic              ram_dop
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [1:0]        req, gnt;
    logic [1:0]        rd_pend;
    logic [DATA_W-1:0] wword;

    // Requests only reach the arbiter in RUN, so neither grants nor the
    // priority pointer move while the array is being cleared.
    assign req = {r1_req, r0_req} & {2{state == RUN}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign r0_gnt    = gnt[0];
    assign r1_gnt    = gnt[1];
    assign r0_rvalid = rd_pend[0];
    assign r1_rvalid = rd_pend[1];
    assign rdata     = {ram_dop, ram_do};
    assign ready     = (state == RUN);
    assign ram_ssr   = 1'b0;
    assign ram_di    = wword[7:0];
    assign ram_dip   = wword[8];

    // State and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: one START cycle, optional clear sweep, then RUN until clr.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            START: begin
                state_nxt = CLEAR_ON_RESET ? CLEAR : RUN;
                cnt_nxt   = '0;
            end
            CLEAR: begin
                if (clr) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = START;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Port-A mux: the sweep owns the port in CLEAR, otherwise the winner does.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        wword    = '0;
        if (state == CLEAR) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = cnt;
            wword    = CLEAR_VAL;
        end else if (gnt[0]) begin
            ram_en   = 1'b1;
            ram_we   = r0_we;
            ram_addr = r0_addr;
            wword    = r0_wdata;
        end else if (gnt[1]) begin
            ram_en   = 1'b1;
            ram_we   = r1_we;
            ram_addr = r1_addr;
            wword    = r1_wdata;
        end
    end

    // A granted read marks its owner so RVALID lines up with the RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 2'b00;
        end else begin
            rd_pend <= {gnt[1] & ~r1_we, gnt[0] & ~r0_we};
        end
    end

endmodule

// File: tb/tb_bram_s9_port_arbiter.sv
// Directed bench for bram_s9_port_arbiter with a behavioural 2K x 9 RAM.
module tb_bram_s9_port_arbiter;

    localparam int AW = 11;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          ready;
    logic          r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [8:0]    r0_wdata;
    logic          r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [8:0]    r1_wdata;
    logic [8:0]    rdata;
    logic          ram_en, ram_we, ram_ssr, ram_dip;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_di;
    logic [7:0]    ram_do;
    logic          ram_dop;

    logic [8:0]    mem [0:2047];
    logic [8:0]    rd_q;
    logic          fill_req;
    logic [8:0]    fill_val;

    int tests_run;
    int tests_failed;

    bram_s9_port_arbiter #(
        .ADDR_W         (AW),
        .CLEAR_ON_RESET (1'b1),
        .CLEAR_VAL      (9'h000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .ready     (ready),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_ssr   (ram_ssr),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_dip   (ram_dip),
        .ram_do    (ram_do),
        .ram_dop   (ram_dop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model with a whole-array fill used for preloading.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 2048; i++) mem[i] <= fill_val;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= {ram_dip, ram_di};
            else        rd_q <= mem[ram_addr];
        end
    end

    assign ram_do  = rd_q[7:0];
    assign ram_dop = rd_q[8];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic applyStimulus(input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [8:0] d0,
                                 input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [8:0] d1,
                                 input logic c);
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        clr = c;
    endtask

    // Follow a clear sweep from counter value 'first' to the end, then expect READY.
    task automatic checkSweep(input int first);
        int bad;
        bad = 0;
        for (int i = first; i < 2048; i++) begin
            @(negedge clk); #1;
            if (!(ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === i[AW-1:0] &&
                  {ram_dip, ram_di} === 9'h000 && ready === 1'b0 &&
                  r0_gnt === 1'b0 && r1_gnt === 1'b0))
                bad++;
        end
        checkOutput("sweep_bad_cycles", bad, 0);
        @(negedge clk); #1;
        checkOutput("sweep_ready", ready, 1);
        checkOutput("sweep_en_off", ram_en, 0);
    endtask

    initial begin
        int bad;
        logic [1:0] prev_gnt;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        fill_req     = 1'b1;
        fill_val     = 9'h1FF;
        applyStimulus(1'b1, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 11'h000, 9'h000, 1'b0);
        @(posedge clk); #1;
        fill_req = 1'b0;

        // Reset state, with requests pending to show grants are held off.
        @(negedge clk); #1;
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_gnt", {r1_gnt, r0_gnt}, 0);
        checkOutput("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
        checkOutput("rst_en", ram_en, 0);
        checkOutput("rst_we", ram_we, 0);
        checkOutput("rst_ssr", ram_ssr, 0);

        // Release: one START cycle, then the full sweep.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("start_ready", ready, 0);
        checkOutput("start_en", ram_en, 0);
        checkSweep(0);

        // Read back the top word, which was 1FF before the sweep.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 11'h7FF, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("rd7ff_gnt", r0_gnt, 1);
        checkOutput("rd7ff_addr", ram_addr, 11'h7FF);
        checkOutput("rd7ff_we", ram_we, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("rd7ff_rvalid", r0_rvalid, 1);
        checkOutput("rd7ff_rdata", rdata, 9'h000);

        // R0 writes 1A5 to 0x123 then reads it back.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 11'h123, 9'h1A5, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("wr_gnt", r0_gnt, 1);
        checkOutput("wr_we", ram_we, 1);
        checkOutput("wr_di", ram_di, 8'hA5);
        checkOutput("wr_dip", ram_dip, 1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 11'h123, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("wr_no_rvalid", r0_rvalid, 0);
        checkOutput("rd123_gnt", r0_gnt, 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("rd123_rvalid", r0_rvalid, 1);
        checkOutput("rd123_rdata", rdata, 9'h1A5);
        checkOutput("rd123_parity", rdata[8], 1);

        // R1 preloads 010..013 at 0..3; the last grant leaves priority with R0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b1, k[AW-1:0], 9'h010 + k[8:0], 1'b0);
            #1;
            checkOutput("pre_gnt", r1_gnt, 1);
        end

        // Continuous contention: grants alternate starting with R0.
        prev_gnt = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 11'h123, 9'h000, 1'b1, 1'b0, 11'h001, 9'h000, 1'b0);
            #1;
            checkOutput("cont_gnt", {r1_gnt, r0_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                checkOutput("cont_rvalid", {r1_rvalid, r0_rvalid}, prev_gnt);
                checkOutput("cont_rdata", rdata, (prev_gnt == 2'b01) ? 9'h1A5 : 9'h011);
            end
            prev_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("cont_last_rvalid", {r1_rvalid, r0_rvalid}, 2'b10);
        checkOutput("cont_last_rdata", rdata, 9'h011);

        // R1 back-to-back reads of 0..3.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, k[AW-1:0], 9'h000, 1'b0);
            #1;
            checkOutput("b2b_gnt", r1_gnt, 1);
            if (k > 0) begin
                checkOutput("b2b_rvalid", r1_rvalid, 1);
                checkOutput("b2b_rdata", rdata, 9'h010 + k[8:0] - 9'h001);
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("b2b_last_rvalid", r1_rvalid, 1);
        checkOutput("b2b_last_rdata", rdata, 9'h013);
        checkOutput("b2b_r0_quiet", r0_rvalid, 0);
        @(negedge clk); #1;
        checkOutput("b2b_rvalid_off", r1_rvalid, 0);

        // CLR during an R0 read: the read completes, then a sweep runs.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 11'h002, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1);
        #1;
        checkOutput("clr_gnt", r0_gnt, 1);
        checkOutput("clr_ready_before", ready, 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("clr_rvalid", r0_rvalid, 1);
        checkOutput("clr_rdata", rdata, 9'h012);
        checkOutput("clr_ready_drop", ready, 0);
        checkOutput("clr_first_write", {ram_en, ram_we, ram_addr}, {2'b11, 11'h000});
        checkSweep(1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 11'h002, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        #1;
        checkOutput("cleared_rvalid", r0_rvalid, 1);
        checkOutput("cleared_rdata", rdata, 9'h000);

        // Reset just after a read grant drops the pending RVALID.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 11'h005, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        checkOutput("abort_rd_pending", r0_rvalid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rd_rvalid", r0_rvalid, 0);
        checkOutput("abort_rd_ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("restart_en", ram_en, 0);

        // Run the sweep up to 0x300, then reset asynchronously mid-cycle.
        bad = 0;
        for (int k = 0; k <= 12'h300; k++) begin
            @(negedge clk); #1;
            if (ram_addr !== k[AW-1:0] || ram_en !== 1'b1) bad++;
        end
        checkOutput("mid_sweep_bad", bad, 0);
        checkOutput("mid_sweep_addr", ram_addr, 11'h300);
        #2;
        applyStimulus(1'b1, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 11'h000, 9'h000, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_ready", ready, 0);
        checkOutput("async_en", ram_en, 0);
        checkOutput("async_we", ram_we, 0);
        checkOutput("async_gnt", {r1_gnt, r0_gnt}, 0);
        checkOutput("async_rvalid", {r1_rvalid, r0_rvalid}, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("resweep_start_en", ram_en, 0);
        @(negedge clk); #1;
        checkOutput("resweep_addr0", {ram_en, ram_addr}, {1'b1, 11'h000});
        @(negedge clk); #1;
        checkOutput("resweep_addr1", {ram_en, ram_addr}, {1'b1, 11'h001});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bram_s9_port_arbiter.md
# bram_s9_port_arbiter

Round-robin arbiter and sequencer for port A of a 2K×9 dual-port block RAM (8 data bits plus 1 parity bit, synchronous read). It shares port A between two requesters with single-cycle grant, one access per clock and fixed 1-cycle read latency. After reset, or on command, it can sweep the whole array with a clear value. Port B of the RAM is outside this block.

## Interface
Parameters:
- ADDR_W, 11, RAM address width; depth = 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = run a full clear sweep after reset release.
- CLEAR_VAL, 9'h000, word written during a sweep, as {parity, data[7:0]}.

Ports:
- CLK  in  1  Single clock for the block and RAM port A.
- RST_N  in  1  Asynchronous, active-low reset.
- CLR  in  1  Start a clear sweep. Sampled on CLK.
- READY  out  1  High in RUN state only.
- Rn_REQ  in  1  Request from requester n (n = 0, 1).
- Rn_WE  in  1  1 = write, 0 = read.
- Rn_ADDR  in  ADDR_W  Access address.
- Rn_WDATA  in  9  Write word, {parity, data}.
- Rn_GNT  out  1  Combinational grant, same cycle as the request.
- Rn_RVALID  out  1  RDATA holds the read result for requester n.
- RDATA  out  9  {RAM_DOP, RAM_DO}, shared by both requesters.
- RAM_EN, RAM_WE  out  1  Port A enable and write enable.
- RAM_SSR  out  1  Tied to 0.
- RAM_ADDR  out  ADDR_W  Port A address.
- RAM_DI  out  8  Port A write data.
- RAM_DIP  out  1  Port A write parity.
- RAM_DO  in  8  Port A read data.
- RAM_DOP  in  1  Port A read parity.

## Operation
- States:
  - START: entered on reset; lasts 1 cycle. Goes to CLEAR if CLEAR_ON_RESET, otherwise to RUN.
  - CLEAR: sweeps the array.
  - RUN: normal arbitration.
- CLEAR:
  - Drives RAM_EN=1, RAM_WE=1, RAM_ADDR=cnt, RAM_DI/RAM_DIP=CLEAR_VAL.
  - cnt starts at 0 and increments every cycle.
  - After the write at cnt = 2**ADDR_W−1, the state goes to RUN and cnt wraps to 0.
  - No grants are issued during CLEAR.
- RUN, arbitration:
  - Rn_GNT = Rn_REQ AND (only n requesting, OR n holds priority).
  - When a grant is issued, RAM_EN=1 and RAM_WE, RAM_ADDR, RAM_DI and RAM_DIP are muxed from the winner.
  - With no request: RAM_EN=0 and RAM_WE=0.
- Priority pointer:
  - Reset value: R0.
  - After any grant, priority passes to the other requester. Under continuous contention, grants strictly alternate.
- Requester handshake:
  - The requester holds REQ and all its fields stable until it sees GNT, then may drop them or present a new access on the next cycle.
  - REQ held high after GNT is treated as a new access.
- Read return:
  - A read granted in cycle t gives Rn_RVALID=1 in cycle t+1, with RDATA = {RAM_DOP, RAM_DO}.
  - Writes produce no RVALID. The RAM output after a write is ignored.
- CLR:
  - Sampled high in RUN: grants in that cycle still proceed and their RVALID still fires next cycle. State goes to CLEAR with cnt=0 next cycle.
  - Sampled high in CLEAR: cnt restarts at 0.
  - CLR held high keeps the block in CLEAR.

## Timing
- Reset values (during reset and in START):
  - State START, cnt=0, priority=R0.
  - READY=0, GNT=0, RVALID=0, RAM_EN=0, RAM_WE=0, RAM_SSR=0.
- Grant latency: 0 cycles. Read data latency: 1 cycle. Throughput: 1 access per cycle, back-to-back with no bubbles.
- A full sweep takes exactly 2**ADDR_W cycles; READY rises the cycle after the last clear write.
- Reset asserted mid-sweep or mid-read aborts all activity. Pending RVALIDs are dropped.
- Same-address access via port B is a system-level hazard and is not checked here.

## Structure
- Package bram_arb_pkg:
  - State enum {START, CLEAR, RUN}.
  - Localparam DATA_W=9 and the default ADDR_W.
- Sub-module rr_arb2: 2-requester round-robin arbiter holding the priority flop, with inputs req[1:0] and output gnt[1:0].
- Top level holds:
  - the FSM;
  - the sweep counter;
  - the per-requester 1-bit read-pending flops that produce RVALID;
  - the RAM port mux.

## Test plan
- Reset with CLEAR_ON_RESET=1, after preloading the RAM with 9'h1FF → exactly 2048 cycles of RAM_EN=RAM_WE=1 over addresses 0..2047, then READY=1; a read of address 0x7FF returns 9'h000.
- R0 writes 9'h1A5 to 0x123, then R0 reads 0x123 → R0_RVALID=1 one cycle after the read grant, RDATA=9'h1A5, parity bit 1.
- R0 and R1 both hold REQ high for 6 cycles → grants alternate R0, R1, R0, R1, R0, R1; RVALIDs follow, each exactly 1 cycle after its grant.
- R1 issues 4 back-to-back reads of 0x000..0x003, preloaded 9'h010..9'h013 → 4 consecutive RVALID cycles with data 9'h010..9'h013, no gaps.
- CLR pulsed during an R0 read grant → R0_RVALID still fires; READY drops next cycle; a 2048-cycle sweep runs; READY returns.
- RST_N asserted asynchronously mid-sweep at cnt=0x300 → all outputs go to reset values immediately; the sweep restarts at 0 after START.
